// File: rtl/draw_arbiter_pkg.sv
// Shared screen geometry, colour codes, requester indices and FSM state type for the draw path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package draw_arbiter_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;

    localparam int DFLT_NREQ  = 3;
    localparam int DFLT_X_W   = 8;
    localparam int DFLT_Y_W   = 7;
    localparam int DFLT_COL_W = 3;

    localparam int REQ_BIRD   = 0;
    localparam int REQ_PIPE   = 1;
    localparam int REQ_CLEAR  = 2;

    localparam logic [DFLT_COL_W-1:0] COL_BLACK   = 3'b000;
    localparam logic [DFLT_COL_W-1:0] COL_GREEN   = 3'b010;
    localparam logic [DFLT_COL_W-1:0] COL_CYAN    = 3'b011;
    localparam logic [DFLT_COL_W-1:0] COL_RED     = 3'b100;
    localparam logic [DFLT_COL_W-1:0] COL_MAGENTA = 3'b101;
    localparam logic [DFLT_COL_W-1:0] COL_YELLOW  = 3'b110;
    localparam logic [DFLT_COL_W-1:0] COL_WHITE   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/draw_arbiter_rect_scanner.sv
// Latches one rectangle and walks it pixel by pixel (x inner, y outer), clipping to the screen.
// Latency: pixel for counter state (cx,cy) is registered on the edge that consumes i_step.
// Backpressure: none; advances on every i_step, o_last flags the final (or empty) step.
// Ports: clk/resetn; i_load + i_x/i_y/i_w/i_h/i_col capture a rect and zero the counters;
//        i_step emits the current pixel; o_plot/o_x/o_y/o_col registered pixel; o_last comb.
module draw_arbiter_rect_scanner
    import draw_arbiter_pkg::*;
#(
    parameter int X_W   = DFLT_X_W,
    parameter int Y_W   = DFLT_Y_W,
    parameter int COL_W = DFLT_COL_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    input  logic [X_W-1:0]   i_w,
    input  logic [Y_W-1:0]   i_h,
    input  logic [COL_W-1:0] i_col,
    output logic             o_last,
    output logic             o_plot,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    output logic [COL_W-1:0] o_col
);

    localparam logic [X_W-1:0] X_ONE = 1;
    localparam logic [Y_W-1:0] Y_ONE = 1;

    logic [X_W-1:0]   r_x, r_w, r_cx;
    logic [Y_W-1:0]   r_y, r_h, r_cy;
    logic [COL_W-1:0] r_col;

    // One bit wider than the coordinate so a rect hanging off the right or
    // bottom edge never wraps back onto the visible screen.
    logic [X_W:0] w_sx;
    logic [Y_W:0] w_sy;
    logic         w_on_screen, w_empty, w_row_end, w_col_end;

    assign w_sx        = {1'b0, r_x} + {1'b0, r_cx};
    assign w_sy        = {1'b0, r_y} + {1'b0, r_cy};
    assign w_on_screen = (w_sx < (X_W+1)'(SCREEN_W)) && (w_sy < (Y_W+1)'(SCREEN_H));
    assign w_empty     = (r_w == '0) || (r_h == '0);
    assign w_row_end   = (r_cx == r_w - X_ONE);
    assign w_col_end   = (r_cy == r_h - Y_ONE);
    assign o_last      = w_empty || (w_row_end && w_col_end);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x    <= '0;
            r_y    <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_col  <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            o_plot <= 1'b0;
            o_x    <= '0;
            o_y    <= '0;
            o_col  <= '0;
        end else begin
            o_plot <= 1'b0;
            if (i_load) begin
                r_x   <= i_x;
                r_y   <= i_y;
                r_w   <= i_w;
                r_h   <= i_h;
                r_col <= i_col;
                r_cx  <= '0;
                r_cy  <= '0;
            end else if (i_step && !w_empty) begin
                // Clipped pixels still consume a scan slot but leave the
                // vga outputs holding the last real pixel.
                o_plot <= w_on_screen;
                if (w_on_screen) begin
                    o_x   <= w_sx[X_W-1:0];
                    o_y   <= w_sy[Y_W-1:0];
                    o_col <= r_col;
                end
                if (w_row_end) begin
                    r_cx <= '0;
                    r_cy <= r_cy + Y_ONE;
                end else begin
                    r_cx <= r_cx + X_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing the vga_adapter write port among rect draw requesters.
// Latency: grant 1 cycle after pick; pixel k at grant+1+k; done at grant+1+w*h (grant+2 if empty).
// Backpressure: losers hold req indefinitely; one cycle of idle after done before the next grant.
// Ports: clk/resetn; req + packed rect_x/y/w/h/col per requester; grant/done one-hot;
//        plot/vga_x/vga_y/vga_colour pixel write; busy = not IDLE.
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter int NREQ  = DFLT_NREQ,
    parameter int X_W   = DFLT_X_W,
    parameter int Y_W   = DFLT_Y_W,
    parameter int COL_W = DFLT_COL_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*X_W-1:0]   rect_x,
    input  logic [NREQ*Y_W-1:0]   rect_y,
    input  logic [NREQ*X_W-1:0]   rect_w,
    input  logic [NREQ*Y_W-1:0]   rect_h,
    input  logic [NREQ*COL_W-1:0] rect_col,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  plot,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COL_W-1:0]      vga_colour,
    output logic                  busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, r_idx, w_pick_idx;
    logic             w_pick_vld, w_go, w_load, w_step, w_last;
    logic [NREQ-1:0]  w_grant_nxt, w_done_nxt;

    // Round-robin pick: scan offsets high to low so the smallest offset from
    // r_rr_ptr is the one left standing.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = IDX_W'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    // The cycle right after done is skipped: the served requester only sees
    // done then, so its req is still high and would be granted a second time.
    assign w_go = (r_state == ST_IDLE) && w_pick_vld && !(|done);

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_go)   w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:             w_state_nxt = ST_IDLE;
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode (registered in the state process below).
    always_comb begin
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_grant_nxt = grant;
        w_done_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (w_go) begin
                    w_load                  = 1'b1;
                    w_grant_nxt[w_pick_idx] = 1'b1;
                end
            end
            ST_SCAN: w_step = 1'b1;
            ST_DONE: begin
                w_grant_nxt       = '0;
                w_done_nxt[r_idx] = 1'b1;
            end
            default: w_grant_nxt = '0;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_idx    <= '0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            grant   <= w_grant_nxt;
            done    <= w_done_nxt;
            busy    <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                r_idx <= w_pick_idx;
            end
            if (r_state == ST_DONE) begin
                r_rr_ptr <= (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    draw_arbiter_rect_scanner #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .COL_W (COL_W)
    ) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_load),
        .i_step (w_step),
        .i_x    (rect_x  [w_pick_idx*X_W   +: X_W]),
        .i_y    (rect_y  [w_pick_idx*Y_W   +: Y_W]),
        .i_w    (rect_w  [w_pick_idx*X_W   +: X_W]),
        .i_h    (rect_h  [w_pick_idx*Y_W   +: Y_W]),
        .i_col  (rect_col[w_pick_idx*COL_W +: COL_W]),
        .o_last (w_last),
        .o_plot (plot),
        .o_x    (vga_x),
        .o_y    (vga_y),
        .o_col  (vga_colour)
    );

endmodule

// File: tb/tb_draw_arbiter.sv
module tb_draw_arbiter;
    import draw_arbiter_pkg::*;

    localparam int N   = DFLT_NREQ;
    localparam int X_W = DFLT_X_W;
    localparam int Y_W = DFLT_Y_W;
    localparam int C_W = DFLT_COL_W;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*X_W-1:0] rect_x = '0, rect_w = '0;
    logic [N*Y_W-1:0] rect_y = '0, rect_h = '0;
    logic [N*C_W-1:0] rect_col = '0;
    logic [N-1:0]     grant, done;
    logic             plot, busy;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [C_W-1:0]   vga_colour;

    draw_arbiter dut (
        .clk(clk), .resetn(resetn), .req(req),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_col(rect_col), .grant(grant), .done(done), .plot(plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int c; int t; } pix_t;
    pix_t sb [N][$];
    int   exp_done_t [N];
    int   vectors = 0;
    int   miscompares = 0;

    // Requester model: load rect fields, queue the expected on-screen pixels
    // with their cycle offset from grant, and raise req.
    task automatic push_rect(input int i, input int x, input int y,
                             input int w, input int h, input int c);
        pix_t p;
        rect_x  [i*X_W +: X_W] = X_W'(x);
        rect_y  [i*Y_W +: Y_W] = Y_W'(y);
        rect_w  [i*X_W +: X_W] = X_W'(w);
        rect_h  [i*Y_W +: Y_W] = Y_W'(h);
        rect_col[i*C_W +: C_W] = C_W'(c);
        for (int cy = 0; cy < h; cy++)
            for (int cx = 0; cx < w; cx++)
                if ((x + cx) < SCREEN_W && (y + cy) < SCREEN_H) begin
                    p.x = x + cx; p.y = y + cy; p.c = c; p.t = cy * w + cx + 1;
                    sb[i].push_back(p);
                end
        exp_done_t[i] = (w * h == 0) ? 2 : w * h + 1;
        req[i] = 1'b1;
    endtask

    // Follow one service of requester idx: grant, every plotted pixel, done.
    // At cycle mut_t the requester scribbles on its rect and drops req.
    task automatic run_rect(input int idx, input int budget, input int mut_t);
        int t = -1;
        bit got = 1'b0;
        pix_t p;
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (t < 0) begin
                if (grant !== '0) begin
                    vectors++;
                    if (grant !== oh || busy !== 1'b1) begin
                        $display("FAIL grant: got grant=%b busy=%b want grant=%b busy=1", grant, busy, oh);
                        miscompares++;
                    end
                    t = 0;
                end
            end else begin
                t++;
                if (t == mut_t) begin
                    rect_x[idx*X_W +: X_W] = X_W'(99);
                    rect_w[idx*X_W +: X_W] = X_W'(7);
                    req[idx] = 1'b0;
                end
                if (plot === 1'b1) begin
                    vectors++;
                    if (sb[idx].size() == 0) begin
                        $display("FAIL extra_plot: got plot at (%0d,%0d) t%0d want none", vga_x, vga_y, t);
                        miscompares++;
                    end else begin
                        p = sb[idx].pop_front();
                        if (vga_x !== X_W'(p.x) || vga_y !== Y_W'(p.y) ||
                            vga_colour !== C_W'(p.c) || t != p.t) begin
                            $display("FAIL pixel: got (%0d,%0d) c%0d t%0d want (%0d,%0d) c%0d t%0d",
                                     vga_x, vga_y, vga_colour, t, p.x, p.y, p.c, p.t);
                            miscompares++;
                        end
                    end
                end
                if (done !== '0) begin
                    vectors++;
                    if (done !== oh || t != exp_done_t[idx] || sb[idx].size() != 0 || grant !== '0) begin
                        $display("FAIL done: got done=%b grant=%b t%0d left=%0d want done=%b grant=000 t%0d left=0",
                                 done, grant, t, sb[idx].size(), oh, exp_done_t[idx]);
                        miscompares++;
                    end
                    req[idx] = 1'b0;
                    got = 1'b1;
                end
            end
        end
        if (!got) begin
            vectors++;
            $display("FAIL timeout: req %0d got no done within %0d cycles (grant t=%0d)", idx, budget, t);
            miscompares++;
            req[idx] = 1'b0;
            sb[idx].delete();
        end
        @(negedge clk);
        vectors++;
        if (done !== '0 || grant !== '0 || busy !== 1'b0) begin
            $display("FAIL after_done: got done=%b grant=%b busy=%b want 000 000 0", done, grant, busy);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({grant, done, plot, vga_x, vga_y, vga_colour, busy} !== '0) begin
            $display("FAIL reset_outputs: got grant=%b done=%b plot=%b xy=(%0d,%0d) c%0d busy=%b want all 0",
                     grant, done, plot, vga_x, vga_y, vga_colour, busy);
            miscompares++;
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || grant !== '0) begin
            $display("FAIL idle_no_req: got busy=%b grant=%b want 0 000", busy, grant);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
        push_rect(REQ_BIRD, 5, 5, 1, 2, COL_RED);
        push_rect(REQ_PIPE, 7, 7, 2, 1, COL_GREEN);
        run_rect(REQ_BIRD, 40, -1);
        run_rect(REQ_PIPE, 40, -1);
        push_rect(REQ_CLEAR, 1, 2, 1, 1, COL_YELLOW);
        push_rect(REQ_BIRD, 3, 4, 1, 1, COL_CYAN);
        run_rect(REQ_CLEAR, 40, -1);
        run_rect(REQ_BIRD, 40, -1);
    endtask

    task automatic test_basic_2x2();
        push_rect(REQ_BIRD, 10, 20, 2, 2, COL_MAGENTA);
        run_rect(REQ_BIRD, 40, -1);
    endtask

    task automatic test_clip();
        push_rect(REQ_CLEAR, 158, 118, 4, 4, COL_WHITE);
        run_rect(REQ_CLEAR, 60, -1);
    endtask

    task automatic test_zero_size();
        push_rect(REQ_BIRD, 30, 30, 0, 5, COL_RED);
        run_rect(REQ_BIRD, 40, -1);
    endtask

    task automatic test_mid_scan_change();
        push_rect(REQ_PIPE, 20, 30, 3, 2, COL_CYAN);
        run_rect(REQ_PIPE, 60, 2);
    endtask

    task automatic test_reset_mid_scan();
        int n = 0;
        push_rect(REQ_BIRD, 0, 0, 10, 10, COL_WHITE);
        while (grant === '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({grant, done, plot, vga_x, vga_y, vga_colour, busy} !== '0 || n >= 20) begin
            $display("FAIL async_reset: got grant=%b done=%b plot=%b xy=(%0d,%0d) busy=%b waited=%0d want all 0",
                     grant, done, plot, vga_x, vga_y, busy, n);
            miscompares++;
        end
        req = '0;
        sb[REQ_BIRD].delete();
        push_rect(REQ_PIPE, 50, 60, 1, 1, COL_GREEN);
        push_rect(REQ_CLEAR, 70, 80, 1, 1, COL_YELLOW);
        @(negedge clk);
        vectors++;
        if (done !== '0) begin
            $display("FAIL done_in_reset: got done=%b want 000", done);
            miscompares++;
        end
        resetn = 1'b1;
        run_rect(REQ_PIPE, 40, -1);
        run_rect(REQ_CLEAR, 40, -1);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic_2x2();
        test_clip();
        test_zero_size();
        test_mid_scan_change();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
